uart_dec_formatter: RTL and testbench

- Converts a binary counter value into fixed-width ASCII decimal text terminated by CR LF.
- Pushes the text byte-by-byte into the TX FIFO that feeds `uart_tx`.
- It is the transmit-side counterpart of the receive path: the design's counter reports its value back over the serial line through this block.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/bin2bcd_serial.sv | 73 +++++++
 rtl/uart_dec_formatter.sv | 136 +++++++++++++
 tb/tb_uart_dec_formatter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the UART decimal formatter.
package uart_pkg;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_SEND = 2'd2
    } fmt_state_e;

    // Double-dabble nibble correction: a nibble of 5..9 would overflow past 9 after the shift.
    function automatic logic [3:0] bcd_add3(input logic [3:0] nib);
        if (nib >= 4'd5) begin
            return nib + 4'd3;
        end else begin
            return nib;
        end
    endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble converter: one input bit per cycle, MSB first.
module bin2bcd_serial
    import uart_pkg::*;
#(
    parameter int DATA_W = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     bin,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  valid
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d, adj_s;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                active_q, active_d;

    // Per-nibble add-3 correction ahead of the shift.
    always_comb begin
        adj_s = '0;
        for (int i = 0; i < DIGITS; i++) begin
            adj_s[4*i +: 4] = bcd_add3(bcd_q[4*i +: 4]);
        end
    end

    // Load on start, otherwise shift one bit while a conversion is running.
    always_comb begin
        shift_d  = shift_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        if (start) begin
            shift_d  = bin;
            bcd_d    = '0;
            cnt_d    = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            shift_d  = {shift_q[DATA_W-2:0], 1'b0};
            bcd_d    = {adj_s[4*DIGITS-2:0], shift_q[DATA_W-1]};
            cnt_d    = cnt_q + CNT_W'(1);
            active_d = (cnt_q != LAST_BIT);
        end else begin
            active_d = 1'b0;
        end
    end

    // Converter state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q  <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    // valid marks the cycle whose closing edge performs the final shift,
    // so the consumer can switch state exactly as bcd becomes final.
    assign bcd   = bcd_q;
    assign valid = active_q & (cnt_q == LAST_BIT);

endmodule

// File: rtl/uart_dec_formatter.sv
// Formats a clamped binary value as fixed-width ASCII decimal plus CR LF
// and pushes it byte-by-byte into the UART TX FIFO.
module uart_dec_formatter
    import uart_pkg::*;
#(
    parameter int DATA_W  = 14,
    parameter int DIGITS  = 4,
    parameter int MAX_VAL = 9999
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              send,
    input  logic [DATA_W-1:0] value,
    input  logic              fifo_full,
    output logic              fifo_wr,
    output logic [7:0]        fifo_wdata,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = $clog2(DIGITS + 2);
    localparam logic [IDX_W-1:0]  IDX_CR    = IDX_W'(DIGITS);
    localparam logic [IDX_W-1:0]  IDX_LF    = IDX_W'(DIGITS + 1);
    localparam logic [DATA_W-1:0] MAX_VAL_C = DATA_W'(MAX_VAL);

    fmt_state_e          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                done_q, done_d;
    logic                start_s, wr_s, conv_valid_s;
    logic [DATA_W-1:0]   clamp_s;
    logic [4*DIGITS-1:0] bcd_s;
    logic [3:0]          digit_s;
    logic [7:0]          byte_s;

    assign clamp_s = (value > MAX_VAL_C) ? MAX_VAL_C : value;

    bin2bcd_serial #(
        .DATA_W (DATA_W),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (start_s),
        .bin   (clamp_s),
        .bcd   (bcd_s),
        .valid (conv_valid_s)
    );

    // Next-state logic: accept, convert, then emit DIGITS+2 bytes under back-pressure.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        start_s = 1'b0;
        wr_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (send) begin
                    start_s = 1'b1;
                    state_d = ST_CONV;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CONV: begin
                if (conv_valid_s) begin
                    state_d = ST_SEND;
                    idx_d   = '0;
                end else begin
                    state_d = ST_CONV;
                end
            end
            ST_SEND: begin
                if (!fifo_full) begin
                    wr_s = 1'b1;
                    if (idx_q == IDX_LF) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    wr_s = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // FSM, byte index and done-pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // Select the BCD digit for the current index, most significant first.
    always_comb begin
        digit_s = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            digit_s = digit_s | ((idx_q == IDX_W'(i)) ? bcd_s[4*(DIGITS-1-i) +: 4] : 4'h0);
        end
    end

    // Output byte mux; idle value is zero.
    always_comb begin
        byte_s = 8'h00;
        if (state_q == ST_SEND) begin
            if (idx_q < IDX_CR) begin
                byte_s = ASCII_ZERO + {4'h0, digit_s};
            end else if (idx_q == IDX_CR) begin
                byte_s = ASCII_CR;
            end else begin
                byte_s = ASCII_LF;
            end
        end else begin
            byte_s = 8'h00;
        end
    end

    assign fifo_wr    = wr_s;
    assign fifo_wdata = byte_s;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;

endmodule

// File: tb/tb_uart_dec_formatter.sv
// Directed self-checking bench for uart_dec_formatter.
module tb_uart_dec_formatter;

    localparam int DATA_W = 14;

    logic              clk = 1'b0;
    logic              rst;
    logic              send;
    logic [DATA_W-1:0] value;
    logic              fifo_full;
    logic              fifo_wr;
    logic [7:0]        fifo_wdata;
    logic              busy;
    logic              done;

    int         n_checks   = 0;
    int         n_errors   = 0;
    int         edge_cnt   = 0;
    int         busy_falls = 0;
    int         n_overrun  = 0;
    int         done_cnt   = 0;
    logic       prev_busy  = 1'b0;
    logic [7:0] wr_data[$];
    int         wr_edge[$];

    uart_dec_formatter #(
        .DATA_W  (14),
        .DIGITS  (4),
        .MAX_VAL (9999)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .send       (send),
        .value      (value),
        .fifo_full  (fifo_full),
        .fifo_wr    (fifo_wr),
        .fifo_wdata (fifo_wdata),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Log each write with the edge number on which the FIFO takes it.
    always @(negedge clk) begin
        if (fifo_wr) begin
            wr_data.push_back(fifo_wdata);
            wr_edge.push_back(edge_cnt + 1);
            if (fifo_full) n_overrun++;
        end
        if (done) done_cnt++;
        if (prev_busy && !busy) busy_falls++;
        prev_busy = busy;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wr_data.delete();
        wr_edge.delete();
        busy_falls = 0;
        n_overrun  = 0;
        done_cnt   = 0;
    endtask

    // Send one value; full_at/full_len hold fifo_full high over edges E(full_at+1)..E(full_at+full_len);
    // extra_at>0 pulses a second send (value 42) sampled at edge E(extra_at).
    task automatic run_msg(input string tag, input logic [DATA_W-1:0] v, input int full_at,
                           input int full_len, input int extra_at, input logic [47:0] exp_bytes,
                           input int exp_first, input int exp_last);
        int   e0;
        int   done_edge;
        bit   seen;
        logic [31:0] obs;
        @(posedge clk); #1;
        clear_log();
        send  = 1'b1;
        value = v;
        e0    = edge_cnt + 1;
        seen  = 1'b0;
        done_edge = -1;
        for (int c = 0; c < 80 && !seen; c++) begin
            @(posedge clk); #1;
            send = (extra_at > 0) && (edge_cnt == e0 + extra_at - 1);
            value = send ? 14'd42 : DATA_W'($urandom_range(16383, 0));
            fifo_full = (edge_cnt >= e0 + full_at) && (edge_cnt < e0 + full_at + full_len);
            @(negedge clk);
            if (c == 0) check_eq({tag, " busy_after_accept"}, {31'd0, busy}, 32'd1);
            if (done) begin
                seen = 1'b1;
                done_edge = edge_cnt;
            end
        end
        send = 1'b0;
        fifo_full = 1'b0;
        check_eq({tag, " done_seen"}, {31'd0, seen}, 32'd1);
        check_eq({tag, " done_edge"}, done_edge, e0 + exp_last);
        check_eq({tag, " write_count"}, wr_data.size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            obs = (i < wr_data.size()) ? {24'd0, wr_data[i]} : 32'hFFFF_FFFF;
            check_eq($sformatf("%s byte%0d", tag, i), obs, {24'd0, exp_bytes[47-8*i -: 8]});
        end
        if (wr_edge.size() == 6) begin
            check_eq({tag, " first_edge"}, wr_edge[0], e0 + exp_first);
            check_eq({tag, " last_edge"}, wr_edge[5], e0 + exp_last);
        end else begin
            check_eq({tag, " edge_log_size"}, wr_edge.size(), 32'd6);
        end
        @(posedge clk); @(negedge clk);
        check_eq({tag, " done_one_cycle"}, {31'd0, done}, 32'd0);
        check_eq({tag, " busy_low"}, {31'd0, busy}, 32'd0);
        repeat (4) @(negedge clk);
        check_eq({tag, " no_extra_writes"}, wr_data.size(), 32'd6);
        check_eq({tag, " busy_falls"}, busy_falls, 32'd1);
        check_eq({tag, " no_overrun"}, n_overrun, 32'd0);
    endtask

    initial begin
        int e0;
        rst = 1'b0; send = 1'b0; value = '0; fifo_full = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst fifo_wr", {31'd0, fifo_wr}, 32'd0);
        check_eq("rst fifo_wdata", {24'd0, fifo_wdata}, 32'd0);
        check_eq("rst busy", {31'd0, busy}, 32'd0);
        check_eq("rst done", {31'd0, done}, 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);

        run_msg("v1234",  14'd1234,  0, 0, 0, 48'h31_32_33_34_0D_0A, 15, 20);
        run_msg("v0",     14'd0,     3, 5, 0, 48'h30_30_30_30_0D_0A, 15, 20);
        run_msg("v9999",  14'd9999,  0, 0, 0, 48'h39_39_39_39_0D_0A, 15, 20);
        run_msg("v12000", 14'd12000, 0, 0, 0, 48'h39_39_39_39_0D_0A, 15, 20);
        run_msg("v16383", 14'd16383, 0, 0, 0, 48'h39_39_39_39_0D_0A, 15, 20);
        run_msg("v507bp", 14'd507,  15, 5, 0, 48'h30_35_30_37_0D_0A, 15, 25);
        run_msg("busyign", 14'd1234, 0, 0, 5, 48'h31_32_33_34_0D_0A, 15, 20);

        // Reset in the middle of SEND, while the third byte is on the bus.
        @(posedge clk); #1;
        clear_log();
        send = 1'b1; value = 14'd1234; e0 = edge_cnt + 1;
        @(posedge clk); #1 send = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        check_eq("midrst third_byte_wr", {31'd0, fifo_wr}, 32'd1);
        check_eq("midrst third_byte", {24'd0, fifo_wdata}, 32'h33);
        #1 rst = 1'b0;
        #1;
        check_eq("midrst fifo_wr", {31'd0, fifo_wr}, 32'd0);
        check_eq("midrst fifo_wdata", {24'd0, fifo_wdata}, 32'd0);
        check_eq("midrst busy", {31'd0, busy}, 32'd0);
        check_eq("midrst done", {31'd0, done}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("midrst writes", wr_data.size(), 32'd2);
        check_eq("midrst no_done", done_cnt, 32'd0);
        check_eq("midrst idle_busy", {31'd0, busy}, 32'd0);

        run_msg("v8", 14'd8, 0, 0, 0, 48'h30_30_30_38_0D_0A, 15, 20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
